// File: rtl/tof_echo_pkg.sv
// Shared types and constants for the time-of-flight echo qualifier/averager.
package tof_echo_pkg;

    // Per-shot classification, listed in evaluation priority after HIT.
    typedef enum logic [2:0] {
        SHOT_HIT    = 3'd0,
        SHOT_MISS   = 3'd1,
        SHOT_NOFALL = 3'd2,
        SHOT_ORDER  = 3'd3,
        SHOT_RANGE  = 3'd4,
        SHOT_WIDTH  = 3'd5
    } shot_class_e;

    // Window state: accumulating shots, or one cycle of clearing after a close.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } win_state_e;

    // Result entry queued for the distance-packing stage.
    typedef struct packed {
        logic        status;
        logic [7:0]  hit_cnt;
        logic [15:0] tof;
        logic [15:0] width;
    } result_t;

    localparam int RESULT_W = 1 + 8 + 16 + 16;

    localparam logic STATUS_FULL = 1'b1;
    localparam logic STATUS_MISS = 1'b0;

    // Saturating 16-bit increment used by the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/tof_echo_average_fifo.sv
// Synchronous show-ahead result FIFO. A push while full is only accepted
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module tof_result_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr_s, do_rd_s;

    assign o_full  = (count_q == DEPTH_C);
    assign o_empty = (count_q == {(AW + 1){1'b0}});
    assign o_head  = mem_q[rd_ptr_q];

    // Decide which side moves this cycle and the resulting pointers/occupancy.
    always_comb begin
        do_rd_s  = i_pop && !o_empty;
        do_wr_s  = i_push && (!o_full || do_rd_s);
        o_drop   = i_push && o_full && !do_rd_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/tof_echo_average.sv
// Per-shot echo qualifier and 2^AVG_LOG2 hit averager with a result FIFO.
module tof_echo_average
    import tof_echo_pkg::*;
#(
    parameter int          AVG_LOG2   = 3,
    parameter logic [7:0]  WIN_SHOTS  = 8'd32,
    parameter logic [15:0] WIDTH_MIN  = 16'd2,
    parameter logic [15:0] WIDTH_MAX  = 16'd4000,
    parameter logic [15:0] RANGE_MAX  = 16'd20000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_rise_data,
    input  logic [15:0] i_fall_data,
    input  logic        i_data_valid,
    output logic        o_result_valid,
    input  logic        i_result_ready,
    output logic [15:0] o_tof_avg,
    output logic [15:0] o_width_avg,
    output logic [7:0]  o_hit_cnt,
    output logic        o_status,
    output logic [15:0] o_err_cnt,
    output logic        o_overflow
);

    localparam int         SUM_W           = 16 + AVG_LOG2;
    localparam logic [7:0] HITS_PER_RESULT = 8'd1 << AVG_LOG2;

    // Stage 1 signals
    shot_class_e cls_d;
    logic [15:0] width_d;
    logic        s1_valid_q;
    shot_class_e s1_class_q;
    logic [15:0] s1_rise_q;
    logic [15:0] s1_width_q;

    // Stage 2 signals
    win_state_e       state_q, state_d;
    logic [7:0]       shot_cnt_q, shot_cnt_d;
    logic [7:0]       hit_cnt_q, hit_cnt_d;
    logic [SUM_W-1:0] tof_sum_q, tof_sum_d;
    logic [SUM_W-1:0] width_sum_q, width_sum_d;
    logic [7:0]       base_shot_s, base_hit_s, shot_new_s, hit_new_s;
    logic [SUM_W-1:0] base_tof_s, base_width_s, tof_new_s, width_new_s;
    logic             is_hit_s, full_close_s, tmo_close_s, push_s;
    result_t          push_entry_s;

    // Error and FIFO signals
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                overflow_q;
    logic [RESULT_W-1:0] push_bits_s, head_bits_s;
    result_t             head_s;
    logic                fifo_full_s, fifo_empty_s, fifo_drop_s, pop_s;

    // Classify the incoming shot; width is only formed when fall follows rise.
    always_comb begin
        width_d = 16'd0;
        cls_d   = SHOT_HIT;
        if (i_fall_data > i_rise_data) begin
            width_d = i_fall_data - i_rise_data;
        end else begin
            width_d = 16'd0;
        end
        if (i_rise_data == 16'd0) begin
            cls_d = SHOT_MISS;
        end else if (i_fall_data == 16'd0) begin
            cls_d = SHOT_NOFALL;
        end else if (i_fall_data <= i_rise_data) begin
            cls_d = SHOT_ORDER;
        end else if (i_rise_data >= RANGE_MAX) begin
            cls_d = SHOT_RANGE;
        end else if ((width_d < WIDTH_MIN) || (width_d > WIDTH_MAX)) begin
            cls_d = SHOT_WIDTH;
        end else begin
            cls_d = SHOT_HIT;
        end
    end

    // Stage 1 register: one classified shot per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_class_q <= SHOT_MISS;
            s1_rise_q  <= 16'd0;
            s1_width_q <= 16'd0;
        end else begin
            s1_valid_q <= i_data_valid;
            s1_class_q <= cls_d;
            s1_rise_q  <= i_rise_data;
            s1_width_q <= width_d;
        end
    end

    // Window FSM next state: accumulate from a cleared base in FLUSH so a
    // shot arriving there becomes the first shot of the new window.
    always_comb begin
        base_shot_s  = shot_cnt_q;
        base_hit_s   = hit_cnt_q;
        base_tof_s   = tof_sum_q;
        base_width_s = width_sum_q;
        case (state_q)
            ST_ACCUM: begin
                base_shot_s  = shot_cnt_q;
                base_hit_s   = hit_cnt_q;
                base_tof_s   = tof_sum_q;
                base_width_s = width_sum_q;
            end
            default: begin
                base_shot_s  = 8'd0;
                base_hit_s   = 8'd0;
                base_tof_s   = {SUM_W{1'b0}};
                base_width_s = {SUM_W{1'b0}};
            end
        endcase

        is_hit_s    = s1_valid_q && (s1_class_q == SHOT_HIT);
        shot_new_s  = base_shot_s + 8'd1;
        hit_new_s   = base_hit_s + (is_hit_s ? 8'd1 : 8'd0);
        tof_new_s   = base_tof_s +
                      (is_hit_s ? {{AVG_LOG2{1'b0}}, s1_rise_q} : {SUM_W{1'b0}});
        width_new_s = base_width_s +
                      (is_hit_s ? {{AVG_LOG2{1'b0}}, s1_width_q} : {SUM_W{1'b0}});

        full_close_s = is_hit_s && (hit_new_s == HITS_PER_RESULT);
        tmo_close_s  = s1_valid_q && !full_close_s && (shot_new_s == WIN_SHOTS);
        push_s       = full_close_s || tmo_close_s;

        if (s1_valid_q) begin
            shot_cnt_d  = shot_new_s;
            hit_cnt_d   = hit_new_s;
            tof_sum_d   = tof_new_s;
            width_sum_d = width_new_s;
        end else begin
            shot_cnt_d  = base_shot_s;
            hit_cnt_d   = base_hit_s;
            tof_sum_d   = base_tof_s;
            width_sum_d = base_width_s;
        end

        push_entry_s.status  = STATUS_MISS;
        push_entry_s.hit_cnt = 8'd0;
        push_entry_s.tof     = 16'd0;
        push_entry_s.width   = 16'd0;
        if (full_close_s) begin
            push_entry_s.status  = STATUS_FULL;
            push_entry_s.hit_cnt = hit_new_s;
            push_entry_s.tof     = tof_new_s[SUM_W-1:AVG_LOG2];
            push_entry_s.width   = width_new_s[SUM_W-1:AVG_LOG2];
        end else if (tmo_close_s) begin
            push_entry_s.status  = STATUS_MISS;
            push_entry_s.hit_cnt = hit_new_s;
        end else begin
            push_entry_s.status  = STATUS_MISS;
        end

        if (push_s) begin
            state_d = ST_FLUSH;
        end else begin
            state_d = ST_ACCUM;
        end
    end

    // Window FSM state and accumulator registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_ACCUM;
            shot_cnt_q  <= 8'd0;
            hit_cnt_q   <= 8'd0;
            tof_sum_q   <= {SUM_W{1'b0}};
            width_sum_q <= {SUM_W{1'b0}};
        end else begin
            state_q     <= state_d;
            shot_cnt_q  <= shot_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            tof_sum_q   <= tof_sum_d;
            width_sum_q <= width_sum_d;
        end
    end

    // Error counter next value: NOFALL and ORDER shots, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s1_valid_q && ((s1_class_q == SHOT_NOFALL) || (s1_class_q == SHOT_ORDER))) begin
            err_cnt_d = sat_inc16(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q  <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            overflow_q <= overflow_q | fifo_drop_s;
        end
    end

    assign push_bits_s = push_entry_s;
    assign head_s      = head_bits_s;
    assign pop_s       = !fifo_empty_s && i_result_ready;

    tof_result_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push_s),
        .i_push_data (push_bits_s),
        .i_pop       (pop_s),
        .o_head      (head_bits_s),
        .o_full      (fifo_full_s),
        .o_empty     (fifo_empty_s),
        .o_drop      (fifo_drop_s)
    );

    // Present the FIFO head; fields read as zero while the FIFO is empty.
    always_comb begin
        o_result_valid = !fifo_empty_s;
        o_err_cnt      = err_cnt_q;
        o_overflow     = overflow_q;
        o_tof_avg      = 16'd0;
        o_width_avg    = 16'd0;
        o_hit_cnt      = 8'd0;
        o_status       = STATUS_MISS;
        if (!fifo_empty_s) begin
            o_tof_avg   = head_s.tof;
            o_width_avg = head_s.width;
            o_hit_cnt   = head_s.hit_cnt;
            o_status    = head_s.status;
        end else begin
            o_tof_avg   = 16'd0;
            o_width_avg = 16'd0;
            o_hit_cnt   = 8'd0;
            o_status    = STATUS_MISS;
        end
    end

endmodule

// File: doc/tof_echo_average.md
# tof_echo_average

Per-shot echo qualifier and averager downstream of the rise/fall edge extractor. Consumes one first-rise/first-fall timestamp pair per laser strobe and classifies each shot as hit, miss or error. Averages 2^AVG_LOG2 qualified hits into one time-of-flight and pulse-width result, then queues results in a small FIFO behind a valid/ready handshake for the distance-packing stage.

## Interface
- AVG_LOG2, 3: log2 of qualified hits per result; legal range 1..6.
- WIN_SHOTS, 8'd32: shots per window before a miss result is forced; must be ≥ 2^AVG_LOG2.
- WIDTH_MIN, 16'd2: minimum accepted pulse width (fall − rise), inclusive.
- WIDTH_MAX, 16'd4000: maximum accepted pulse width, inclusive.
- RANGE_MAX, 16'd20000: rise timestamps ≥ this value are rejected.
- FIFO_DEPTH, 4: number of result entries; power of two.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_rise_data  in  16  first rise timestamp of the shot; 0 means no echo.
- i_fall_data  in  16  first fall timestamp of the shot; 0 means no fall edge.
- i_data_valid  in  1  single-cycle per-shot strobe; may be asserted on back-to-back cycles.
- o_result_valid  out  1  FIFO head valid.
- i_result_ready  in  1  consumer accepts the head on valid&ready.
- o_tof_avg  out  16  averaged rise timestamp.
- o_width_avg  out  16  averaged pulse width.
- o_hit_cnt  out  8  qualified hits in the window.
- o_status  out  1  1 = full average, 0 = window timed out (miss).
- o_err_cnt  out  16  saturating count of NOFALL and ORDER errors.
- o_overflow  out  1  sticky; set when a result is dropped because the FIFO is full.

## Operation
- Stage 1 registers the shot class, evaluated in priority order:
  - MISS: rise == 0.
  - NOFALL: fall == 0.
  - ORDER: fall ≤ rise.
  - RANGE: rise ≥ RANGE_MAX.
  - WIDTH: width < WIDTH_MIN or width > WIDTH_MAX.
  - HIT: otherwise.
- Width is a 16-bit subtraction, computed only when fall > rise.
- NOFALL and ORDER increment o_err_cnt, which saturates at 16'hFFFF.
- Stage 2 uses a two-state window FSM:
  - ACCUM: each registered shot increments shot_cnt.
  - HIT also increments hit_cnt and adds rise to tof_sum and width to width_sum. Both sums are 16+AVG_LOG2 bits wide.
- Window close:
  - If the current shot is a HIT that makes hit_cnt == 2^AVG_LOG2, push {status=1, hit_cnt, (tof_sum+rise)>>AVG_LOG2, (width_sum+width)>>AVG_LOG2}.
  - Else, if the current shot makes shot_cnt == WIN_SHOTS, push {status=0, hit_cnt, 0, 0}.
  - If both conditions are true on the same shot, the full average wins.
  - On either close, the FSM enters FLUSH for exactly one cycle, clearing the accumulators and counters, then returns to ACCUM.
  - A shot arriving during FLUSH is the first shot of the new window. No shot is lost.
- FIFO:
  - Show-ahead: o_result_* present the head whenever o_result_valid = 1.
  - Pop on valid&ready.
  - A push while full drops the new entry and sets o_overflow.
  - A push and pop in the same cycle while full is accepted with no drop.
  - No pop occurs while empty.
- Reset clears the FSM (to ACCUM), all sums and counters, the FIFO pointers, o_err_cnt and o_overflow. Any partial window is discarded.
- Output reset values: o_result_valid=0, o_tof_avg=0, o_width_avg=0, o_hit_cnt=0, o_status=0, o_err_cnt=0, o_overflow=0.

## Timing
- Shot on i_data_valid in cycle N: the class is registered at the edge ending cycle N; accumulators update and the FIFO is written at the edge ending N+1.
- Result latency: o_result_valid rises in cycle N+2 when the FIFO was empty.
- o_err_cnt reflects the shot in cycle N+2.
- Throughput is one shot per cycle, sustained indefinitely.
- The head changes on the cycle after a pop.
- o_overflow rises in the cycle after the dropped push.
- Reset asserted in any cycle takes effect at that edge. The first shot accepted after deassertion starts a fresh window.

## Structure
- Package tof_echo_pkg holds:
  - Shot class enum: HIT, MISS, NOFALL, ORDER, RANGE, WIDTH.
  - Result entry struct and its width (1+8+16+16 = 41 bits).
  - Status constants.
- Sub-module tof_result_fifo: parameterised synchronous show-ahead FIFO with full/empty flags, instantiated once.
- The classifier and the accumulator FSM stay in the top module.

## Test plan
All scenarios use AVG_LOG2=2 and WIN_SHOTS=8 unless stated.
- Full average: rise 100/102/104/106 with fall 150 each → one result with tof=103, width=47, hit_cnt=4, status=1; valid exactly 2 cycles after the 4th strobe.
- Timeout: 8 shots with rise=0 → one result with status=0, hit_cnt=0, tof=0, width=0. Repeat with 3 hits plus 5 misses → hit_cnt=3, status=0.
- Errors: rise=200, fall=0 → err_cnt=1. Then rise=300, fall=300 → err_cnt=2. Neither shot counts as a hit.
- Boundaries:
  - width=4000 is accepted; width=4001 is rejected.
  - rise=19999 is accepted; rise=20000 is rejected.
  - width=2 is accepted; width=1 is rejected.
- Back-pressure: ready=0 with 5 full windows (20 back-to-back hits) → 4 results held and o_overflow=1. Raising ready drains the 4 results in order; pop and push in the same cycle while full causes no drop.
- Reset mid-window: 2 hits, then reset for 1 cycle, then hits with rise 10/10/10/10 and fall 20 each → result tof=10, width=10, hit_cnt=4, err_cnt=0.
